sr_bank_writer: RTL and testbench

SR_BANK_WRITER -- requirements
Module: sr_bank_writer

---
 rtl/sr_bank_writer.sv | 142 ++++++++++++++
 tb/tb_sr_bank_writer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sr_bank_writer.sv
// Writes a value into a bank of SR flip-flops using one-cycle set/reset pulses followed by a settle
// window. Optional readback check is enabled by defining SR_BANK_WRITER_READBACK_CHECK_EN.
module sr_bank_writer #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] shadow,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] StInit   = 3'd0;
  localparam logic [2:0] StIdle   = 3'd1;
  localparam logic [2:0] StSet    = 3'd2;
  localparam logic [2:0] StRst    = 3'd3;
  localparam logic [2:0] StSettle = 3'd4;
  localparam logic [2:0] StCheck  = 3'd5;

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] set_mask_q, set_mask_d;
  logic [WIDTH-1:0] rst_mask_q, rst_mask_d;
  logic             init_q, init_d;
  logic [WIDTH-1:0] s_out_q, r_out_q, shadow_q;
  logic             done_q, wr_ready_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    set_mask_d = set_mask_q;
    rst_mask_d = rst_mask_q;
    init_d     = init_q;
    case (state_q)
      StInit: begin
        state_d = StSettle;
        cnt_d   = '0;
        init_d  = 1'b1;
      end
      StIdle: begin
        if (wr_valid) begin
          data_d     = wr_data;
          set_mask_d = wr_data & ~shadow_q;
          rst_mask_d = ~wr_data & shadow_q;
          if (|set_mask_d) begin
            state_d = StSet;
          end else if (|rst_mask_d) begin
            state_d = StRst;
          end else begin
            state_d = StCheck;
          end
        end
      end
      StSet: begin
        state_d = (|rst_mask_q) ? StRst : StSettle;
        cnt_d   = '0;
      end
      StRst: begin
        state_d = StSettle;
        cnt_d   = '0;
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          // The power-up clear has nothing to commit, so it skips CHECK.
          state_d = init_q ? StIdle : StCheck;
          init_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StCheck: state_d = StIdle;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      cnt_q      <= '0;
      data_q     <= '0;
      set_mask_q <= '0;
      rst_mask_q <= '0;
      init_q     <= 1'b0;
      s_out_q    <= '0;
      r_out_q    <= '0;
      shadow_q   <= '0;
      done_q     <= 1'b0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      set_mask_q <= set_mask_d;
      rst_mask_q <= rst_mask_d;
      init_q     <= init_d;
      // Pulses come only from mutually exclusive states, so S and R never overlap.
      s_out_q    <= (state_q == StSet) ? set_mask_q : '0;
      r_out_q    <= (state_q == StRst)  ? rst_mask_q :
                    (state_q == StInit) ? '1 : '0;
      done_q     <= (state_q == StCheck);
      wr_ready_q <= (state_d == StIdle);
      if (state_q == StCheck) shadow_q <= data_q;
    end
  end

`ifdef SR_BANK_WRITER_READBACK_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((state_q == StCheck) && (q_in != data_q)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_q_in;
  assign unused_q_in = ^q_in;
  assign err         = 1'b0;
`endif

  assign s_out    = s_out_q;
  assign r_out    = r_out_q;
  assign shadow   = shadow_q;
  assign done     = done_q;
  assign wr_ready = wr_ready_q;

endmodule

// File: tb/tb_sr_bank_writer.sv
// Scoreboard bench for sr_bank_writer: expected pulses and commits are queued by the driver and
// popped by negedge monitors; q_in comes from a simple SR bank model.
module tb_sr_bank_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready;
  logic [7:0] s_out, r_out, q_in, shadow;
  logic       done, err;

  logic [7:0] bank = 8'h3C;
  logic       force_q = 1'b0;

`ifdef SR_BANK_WRITER_READBACK_CHECK_EN
  localparam logic ErrExp = 1'b1;
`else
  localparam logic ErrExp = 1'b0;
`endif

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int acc_cyc = 0;
  logic [7:0] acc_data = 8'h00;
  int done_cnt = 0;
  int done_cyc = 0;

  logic [15:0] pulse_q[$];
  logic [8:0]  done_q[$];

  sr_bank_writer #(
    .WIDTH(8),
    .SETTLE_CYCLES(2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data (wr_data),
    .s_out   (s_out),
    .r_out   (r_out),
    .q_in    (q_in),
    .shadow  (shadow),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    bank <= (bank & ~r_out) | s_out;
  end

  assign q_in = force_q ? 8'h00 : bank;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Inputs change only #1 after posedge, so a negedge handshake sample predicts the next edge.
  always @(negedge clk) begin
    if (rst_n && wr_valid && wr_ready) begin
      acc_cnt++;
      acc_cyc  = cyc + 1;
      acc_data = wr_data;
    end
  end

  always @(negedge clk) begin
    logic [15:0] pe;
    if (s_out != 8'h00 || r_out != 8'h00) begin
      if (pulse_q.size() == 0) begin
        check("unexpected_pulse", {s_out, r_out}, 16'h0000);
      end else begin
        pe = pulse_q.pop_front();
        check("pulse", {s_out, r_out}, pe);
        check("no_overlap", s_out & r_out, 8'h00);
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] de;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (done_q.size() == 0) begin
        check("unexpected_done", {err, shadow}, 9'h000);
      end else begin
        de = done_q.pop_front();
        check("commit", {err, shadow}, de);
      end
    end
  end

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_cnt < target && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    check("accept_seen", acc_cnt, target);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    check("done_seen", done_cnt, target);
  endtask

  task automatic wait_ready_after_reset();
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!wr_ready && n < 20);
    check("init_to_ready", n, 3);
  endtask

  task automatic do_write(input logic [7:0] d, input int exp_lat);
    int a0 = acc_cnt;
    int d0 = done_cnt;
    @(posedge clk); #1;
    wr_valid = 1'b1;
    wr_data  = d;
    wait_acc(a0 + 1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wr_data  = ~d;
    wait_done(d0 + 1);
    check("latency", done_cyc - acc_cyc, exp_lat);
  endtask

  initial begin
    int a0;
    int d0;
    repeat (2) @(negedge clk);
    check("rst_s_out", s_out, 8'h00);
    check("rst_r_out", r_out, 8'h00);
    check("rst_shadow", shadow, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b0);

    pulse_q.push_back({8'h00, 8'hFF});
    #1 rst_n = 1'b1;
    wait_ready_after_reset();

    pulse_q.push_back({8'hA5, 8'h00});
    done_q.push_back({1'b0, 8'hA5});
    do_write(8'hA5, 4);

    pulse_q.push_back({8'h5A, 8'h00});
    pulse_q.push_back({8'h00, 8'hA5});
    done_q.push_back({1'b0, 8'h5A});
    do_write(8'h5A, 5);

    done_q.push_back({1'b0, 8'h5A});
    do_write(8'h5A, 1);

    // Readback forced wrong for one write; err must stick afterwards when checking is enabled.
    force_q = 1'b1;
    pulse_q.push_back({8'h05, 8'h00});
    pulse_q.push_back({8'h00, 8'h50});
    done_q.push_back({ErrExp, 8'h0F});
    do_write(8'h0F, 5);
    force_q = 1'b0;

    pulse_q.push_back({8'h00, 8'h0F});
    done_q.push_back({ErrExp, 8'h00});
    do_write(8'h00, 4);

    // Hold wr_valid through a busy write; the second value must be taken exactly once.
    pulse_q.push_back({8'hFF, 8'h00});
    pulse_q.push_back({8'h00, 8'hCC});
    done_q.push_back({ErrExp, 8'hFF});
    done_q.push_back({ErrExp, 8'h33});
    a0 = acc_cnt;
    d0 = done_cnt;
    @(posedge clk); #1;
    wr_valid = 1'b1;
    wr_data  = 8'hFF;
    wait_acc(a0 + 1);
    @(posedge clk); #1;
    wr_data = 8'h33;
    wait_acc(a0 + 2);
    check("held_accept_cycle", acc_cyc, done_cyc + 1);
    check("held_accept_data", acc_data, 8'h33);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wait_done(d0 + 2);
    repeat (5) @(posedge clk);
    check("held_accept_count", acc_cnt, a0 + 2);

    // Reset during SETTLE: pulse already issued, no commit may follow.
    pulse_q.push_back({8'h0C, 8'h00});
    a0 = acc_cnt;
    @(posedge clk); #1;
    wr_valid = 1'b1;
    wr_data  = 8'h3F;
    wait_acc(a0 + 1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {s_out, r_out, shadow, done, err, wr_ready}, 27'h0);
    repeat (3) @(negedge clk);
    pulse_q.push_back({8'h00, 8'hFF});
    #1 rst_n = 1'b1;
    wait_ready_after_reset();
    check("midrst_shadow", shadow, 8'h00);
    check("midrst_err", err, 1'b0);

    pulse_q.push_back({8'h81, 8'h00});
    done_q.push_back({1'b0, 8'h81});
    do_write(8'h81, 4);

    repeat (6) @(posedge clk);
    check("pulse_queue_empty", pulse_q.size(), 0);
    check("done_queue_empty", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
